// File: rtl/fp_result_retire_if.sv
// Result-retire handshake bundle: producer-side push channel and
// writeback-side pop channel of the FP result FIFO.
interface fp_result_retire_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [4:0]       inRegAddr;
  logic             inIsIntDest;
  logic [31:0]      inIntResult;
  logic [WIDTH-1:0] inFpResult;
  logic [4:0]       inFlags;

  logic             outValid;
  logic             outReady;
  logic [4:0]       outRegAddr;
  logic             outIsIntDest;
  logic [WIDTH-1:0] outData;

  modport master (
    output inValid, inRegAddr, inIsIntDest, inIntResult, inFpResult, inFlags,
    output outReady,
    input  inReady, outValid, outRegAddr, outIsIntDest, outData
  );

  modport slave (
    input  inValid, inRegAddr, inIsIntDest, inIntResult, inFpResult, inFlags,
    input  outReady,
    output inReady, outValid, outRegAddr, outIsIntDest, outData
  );
endinterface

// File: rtl/fp_result_retire.sv
// In-order FIFO between FP execution units and register writeback; retires
// exception flags into the sticky fflags register and merges CSR writes.
module fp_result_retire #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_result_retire_if.slave      bus,
  input  logic                   flush,
  input  logic                   csrWriteEnable,
  input  logic [4:0]             csrWriteValue,
  output logic [4:0]             fflags,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0]       data_mem  [DEPTH];
  logic [4:0]             addr_mem  [DEPTH];
  logic                   int_mem   [DEPTH];
  logic [4:0]             flags_mem [DEPTH];

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   full;
  logic                   empty;
  logic                   in_ready;
  logic                   push;
  logic                   pop;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic [4:0]             retire_flags;
  logic [WIDTH-1:0]       entry_data;

  function automatic logic [WIDTH-1:0] select_result(
    input logic             is_int,
    input logic [31:0]      int_res,
    input logic [WIDTH-1:0] fp_res
  );
    return is_int ? WIDTH'(int_res) : fp_res;
  endfunction

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];
  assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full && !flush && !rst;
  assign push     = bus.inValid && in_ready;
  assign pop      = !empty && bus.outReady;

  assign retire_flags = pop ? flags_mem[rd_idx] : 5'b0;
  assign entry_data   = select_result(bus.inIsIntDest, bus.inIntResult, bus.inFpResult);

  assign bus.inReady      = in_ready;
  assign bus.outValid     = !empty;
  assign bus.outRegAddr   = addr_mem[rd_idx];
  assign bus.outIsIntDest = int_mem[rd_idx];
  assign bus.outData      = data_mem[rd_idx];
  assign count            = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= '0;
        addr_mem[i]  <= '0;
        int_mem[i]   <= 1'b0;
        flags_mem[i] <= '0;
      end
    end else if (push) begin
      data_mem[wr_idx]  <= entry_data;
      addr_mem[wr_idx]  <= bus.inRegAddr;
      int_mem[wr_idx]   <= bus.inIsIntDest;
      flags_mem[wr_idx] <= bus.inFlags;
    end
  end

  // Flush drops every buffered entry; only the head popping this cycle retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The retiring op is ordered after a same-cycle CSR write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else begin
      fflags <= (csrWriteEnable ? csrWriteValue : fflags) | retire_flags;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_count_match:  assert property (@(posedge clk) disable iff (rst)
                                   count_q == COUNT_WIDTH'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_fp_result_retire.sv
// Directed bench for fp_result_retire (WIDTH=32, DEPTH=2).
module tb_fp_result_retire;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       csrWriteEnable;
  logic [4:0] csrWriteValue;
  logic [4:0] fflags;
  logic [1:0] count;

  int errors = 0;
  int checks = 0;

  fp_result_retire_if #(.WIDTH(32)) bus ();

  fp_result_retire #(.WIDTH(32), .DEPTH(2), .COUNT_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .flush          (flush),
    .csrWriteEnable (csrWriteEnable),
    .csrWriteValue  (csrWriteValue),
    .fflags         (fflags),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic is_int, input logic [31:0] val,
                            input logic [4:0] rd, input logic [4:0] flg);
    bus.inValid     = 1'b1;
    bus.inIsIntDest = is_int;
    bus.inIntResult = is_int ? val : 32'h0;
    bus.inFpResult  = is_int ? 32'h0 : val;
    bus.inRegAddr   = rd;
    bus.inFlags     = flg;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; csrWriteEnable = 1'b0; csrWriteValue = '0;
    bus.inValid = 1'b0; bus.inIsIntDest = 1'b0; bus.inIntResult = '0;
    bus.inFpResult = '0; bus.inRegAddr = '0; bus.inFlags = '0; bus.outReady = 1'b0;
    tick();
    check("rst_inReady", 32'(bus.inReady), 32'h0);
    check("rst_outValid", 32'(bus.outValid), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("idle_inReady", 32'(bus.inReady), 32'h1);
    check("idle_outValid", 32'(bus.outValid), 32'h0);
    check("idle_count", 32'(count), 32'h0);
    check("idle_fflags", 32'(fflags), 32'h0);
    check("idle_outData", bus.outData, 32'h0);

    // FEQ result to x5, held while writeback stalls
    drive_push(1'b1, 32'h1, 5'd5, 5'b0);
    tick();
    bus.inValid = 1'b0;
    check("feq_outValid", 32'(bus.outValid), 32'h1);
    check("feq_outData", bus.outData, 32'h1);
    check("feq_outRegAddr", 32'(bus.outRegAddr), 32'h5);
    check("feq_isInt", 32'(bus.outIsIntDest), 32'h1);
    tick();
    check("feq_hold", 32'(bus.outValid), 32'h1);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    check("feq_popped", 32'(bus.outValid), 32'h0);
    check("feq_count0", 32'(count), 32'h0);

    // FMIN NaN with NV, then a second entry: fill, then drain in order
    drive_push(1'b0, 32'h7FC00000, 5'd3, 5'b10000);
    tick();
    drive_push(1'b0, 32'h3F800000, 5'd4, 5'b00000);
    tick();
    bus.inValid = 1'b0;
    check("full_count", 32'(count), 32'h2);
    check("full_inReady", 32'(bus.inReady), 32'h0);
    check("full_head", bus.outData, 32'h7FC00000);
    check("full_isInt", 32'(bus.outIsIntDest), 32'h0);
    bus.outReady = 1'b1;
    #1;
    check("full_pop_inReady", 32'(bus.inReady), 32'h0);
    tick();
    check("pop1_fflags", 32'(fflags), 32'h10);
    check("pop1_head", bus.outData, 32'h3F800000);
    check("pop1_rd", 32'(bus.outRegAddr), 32'h4);
    check("pop1_count", 32'(count), 32'h1);
    tick();
    bus.outReady = 1'b0;
    check("pop2_count", 32'(count), 32'h0);
    check("pop2_outValid", 32'(bus.outValid), 32'h0);
    check("pop2_fflags", 32'(fflags), 32'h10);

    // Streaming at occupancy 1: pointers wrap repeatedly
    drive_push(1'b1, 32'd100, 5'd7, 5'b0);
    tick();
    bus.outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(1'b1, 32'(101 + i), 5'd7, 5'b0);
      #1;
      check("stream_data", bus.outData, 32'(100 + i));
      check("stream_inReady", 32'(bus.inReady), 32'h1);
      tick();
    end
    bus.inValid = 1'b0;
    check("stream_count", 32'(count), 32'h1);
    check("stream_last", bus.outData, 32'd110);
    tick();
    bus.outReady = 1'b0;
    check("stream_drained", 32'(count), 32'h0);

    // CSR write merges with a same-cycle retire
    csrWriteEnable = 1'b1; csrWriteValue = 5'b00000;
    drive_push(1'b0, 32'h40000000, 5'd9, 5'b10000);
    tick();
    bus.inValid = 1'b0;
    check("csr_clear", 32'(fflags), 32'h0);
    csrWriteValue = 5'b00001; bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    check("csr_plus_retire", 32'(fflags), 32'h11);
    csrWriteValue = 5'b00000;
    tick();
    csrWriteEnable = 1'b0;
    check("csr_zero", 32'(fflags), 32'h0);

    // Flush with NV and NX entries buffered
    csrWriteEnable = 1'b1; csrWriteValue = 5'b00100;
    drive_push(1'b0, 32'h11111111, 5'd1, 5'b10000);
    tick();
    csrWriteEnable = 1'b0;
    drive_push(1'b0, 32'h22222222, 5'd2, 5'b00001);
    tick();
    check("preflush_count", 32'(count), 32'h2);
    check("preflush_fflags", 32'(fflags), 32'h4);
    flush = 1'b1;
    drive_push(1'b1, 32'hDEAD, 5'd6, 5'b01000);
    #1;
    check("flush_inReady", 32'(bus.inReady), 32'h0);
    tick();
    flush = 1'b0; bus.inValid = 1'b0;
    check("flush_count", 32'(count), 32'h0);
    check("flush_outValid", 32'(bus.outValid), 32'h0);
    check("flush_fflags", 32'(fflags), 32'h4);
    tick();
    check("flush_no_push", 32'(count), 32'h0);

    // Async reset mid-stream
    drive_push(1'b0, 32'h33333333, 5'd3, 5'b0);
    tick();
    drive_push(1'b0, 32'h44444444, 5'd4, 5'b0);
    tick();
    bus.inValid = 1'b0;
    check("prerst_count", 32'(count), 32'h2);
    rst = 1'b1;
    #1;
    check("arst_outValid", 32'(bus.outValid), 32'h0);
    check("arst_fflags", 32'(fflags), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_outData", bus.outData, 32'h0);
    tick();
    rst = 1'b0;
    #1;

    // Flush coinciding with a pop still retires the head's flags
    drive_push(1'b0, 32'h55555555, 5'd8, 5'b01000);
    tick();
    bus.inValid = 1'b0;
    flush = 1'b1; bus.outReady = 1'b1;
    tick();
    flush = 1'b0; bus.outReady = 1'b0;
    check("flushpop_fflags", 32'(fflags), 32'h8);
    check("flushpop_count", 32'(count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
